neo_reset_gen: RTL



---
 rtl/neo_reset_pkg.sv | 23 ++
 rtl/neo_wdog_counter.sv | 49 ++++
 rtl/neo_reset_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/neo_reset_pkg.sv
// Shared constants and state encoding for the NeoGeo system reset generator.
// Optional watchdog path is selected with the NEO_WDOG_EN macro.
package neo_reset_pkg;

    // Rate of the CLK_EN_24_N phase enable; all reset timing is counted in these ticks.
    localparam int unsigned TICK_HZ     = 24_000_000;

    // Watchdog window of ~0.135 s at TICK_HZ (3244032 / 24e6 = 0.13517 s).
    localparam int unsigned DEF_TIMEOUT = 3_244_032;

    // Ticks nRESET stays low after the last reset cause goes away.
    localparam int unsigned DEF_HOLD    = 64;

    // Counter widths sized so the terminal compare is always reached before a wrap.
    localparam int unsigned DEF_CW      = 22;
    localparam int unsigned DEF_HW      = 8;

    // Reset sequencer state: HOLD drives nRESET low, RUN releases it.
    typedef logic [0:0] rst_state_t;
    localparam rst_state_t ST_HOLD = 1'b0;
    localparam rst_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/neo_wdog_counter.sv
// Watchdog counter: kick latch, tick counter and timeout compare.
// Instantiated only when NEO_WDOG_EN is defined.
module neo_wdog_counter
    import neo_reset_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CW      = DEF_CW
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic kick,
    input  logic run,
    output logic timeout
);

    logic          kick_pend_q, kick_pend_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    // Kicks may arrive in any cycle; they are merged and consumed by the following tick.
    // Outside RUN the counter is held at zero, so kicks seen there are simply dropped.
    always_comb begin
        kick_pend_d = kick | (kick_pend_q & ~tick);
        wd_cnt_d    = wd_cnt_q;
        timeout     = 1'b0;
        if (tick) begin
            if (!run || kick_pend_q) begin
                wd_cnt_d = '0;
            end else if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
                wd_cnt_d = '0;
                timeout  = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end
    end

    // Counter and kick latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kick_pend_q <= 1'b0;
            wd_cnt_q    <= '0;
        end else begin
            kick_pend_q <= kick_pend_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

endmodule

// File: rtl/neo_reset_gen.sv
// NeoGeo system reset generator: merges power-on, host request and watchdog
// into the registered active-low nRESET level, updated on 24 MHz ticks only.
// Define NEO_WDOG_EN to build the watchdog; otherwise WDOG_KICK is ignored.
module neo_reset_gen
    import neo_reset_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned HOLD    = DEF_HOLD,
    parameter int unsigned CW      = DEF_CW,
    parameter int unsigned HW      = DEF_HW
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLK_EN_24_N,
    input  logic WDOG_KICK,
    input  logic SYS_RESET_REQ,
    output logic nRESET,
    output logic WDOG_FIRED
);

    rst_state_t    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          nreset_q, nreset_d;
    logic          fired_q, fired_d;
    logic          wd_timeout;

`ifdef NEO_WDOG_EN
    // A host request in RUN outranks the watchdog, so the counter is parked for that tick.
    neo_wdog_counter #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_wdog (
        .clk     (CLK),
        .rst     (RESET),
        .tick    (CLK_EN_24_N),
        .kick    (WDOG_KICK),
        .run     ((state_q == ST_RUN) && !SYS_RESET_REQ),
        .timeout (wd_timeout)
    );
`else
    logic unused_wdog_kick;
    localparam int unsigned UNUSED_WDOG_CFG = TIMEOUT + CW;
    assign unused_wdog_kick = WDOG_KICK;
    assign wd_timeout       = 1'b0;
`endif

    // HOLD counts consecutive request-free ticks; RUN waits for a request or a timeout.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        nreset_d   = nreset_q;
        fired_d    = fired_q;
        if (CLK_EN_24_N) begin
            case (state_q)
                ST_HOLD: begin
                    if (SYS_RESET_REQ) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HW'(HOLD - 1)) begin
                        state_d  = ST_RUN;
                        nreset_d = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (SYS_RESET_REQ) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                        nreset_d   = 1'b0;
                        fired_d    = 1'b0;
                    end else if (wd_timeout) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                        nreset_d   = 1'b0;
                        fired_d    = 1'b1;
                    end
                end
            endcase
        end
    end

    // Sequencer registers; RESET aborts any sequence and restarts a full hold.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            nreset_q   <= 1'b0;
            fired_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            nreset_q   <= nreset_d;
            fired_q    <= fired_d;
        end
    end

    assign nRESET     = nreset_q;
    assign WDOG_FIRED = fired_q;

endmodule
